key_expansion_ctrl: RTL
=======================

Name: key_expansion_ctrl

Overview:
- Sequences the single-round AES-128 key schedule stage through rounds 0..10 for one cipher key.
- Captures all 11 round keys into an on-block round-key store.
- Serves round keys to the cipher/decipher cores through an indexed read port, so decryption can walk rounds 10..0.
- Sits between the key-load interface and the round datapaths.

Parameters:
- NR, 10, number of rounds; only 10 (AES-128) is supported, and elaboration fails otherwise.
- KEY_W, 128, key and round-key width.
- CTR_W, 4, width of the round counter driven to the key schedule stage.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request expansion of key_in; accepted only when ready=1.
- key_in  input  KEY_W  cipher key; sampled on the accepting edge only.
- ready  output  1  high in IDLE; start accepted when start&ready.
- busy  output  1  high from the accepting edge until keys_valid rises.
- done  output  1  one-cycle pulse, coincident with keys_valid rising.
- keys_valid  output  1  level; all 11 round keys are stored and readable.
- rd_en  input  1  round-key read request.
- rd_round  input  4  round index 0..10.
- rd_key  output  KEY_W  registered read data.
- rd_valid  output  1  pulse, one cycle after rd_en.
- rd_err  output  1  pulse with rd_valid when the read was illegal.

Behaviour:
- Reset (async, takes effect immediately):
  - state=IDLE, ctr=0, ready=1.
  - busy, done, keys_valid, rd_valid, rd_err all 0; rd_key=0.
  - Key register and round-key store contents are don't-care; keys_valid=0 gates all use of them.
  - Reset mid-expansion abandons the expansion; no partial keys_valid.
- FSM states: IDLE, LOAD, GEN, STORE.
  - IDLE: ready=1. On start, latch key_reg<=key_in; go to LOAD; ready=0, busy=1, keys_valid<=0.
  - LOAD: drive ctr=0 and key_reg to the stage input. The stage output becomes round key 0 at the next edge. Go to GEN with ctr<=1.
  - GEN: drive ctr=k, k=1..10.
    - At each edge, write store[k-1] <= stage output (round key k-1) and increment ctr.
    - At the k=10 edge, write store[9] and go to STORE; ctr holds at 10.
    - Never drive ctr=0 outside LOAD, because that reloads the stage.
  - STORE: write store[10] <= stage output (round key 10), set keys_valid=1, pulse done, clear busy, go to IDLE.
- Latency: the accepting edge is T0; keys_valid and done are high after edge T12 (12 cycles).
- start while ready=0 is ignored; there is no queueing.
- start while keys_valid=1 is accepted; keys_valid drops after the accepting edge.
- Read port:
  - rd_en sampled at edge; rd_key and rd_valid appear after that edge (1-cycle latency).
  - Legal read (keys_valid=1, rd_round<=10): rd_key=store[rd_round], rd_err=0.
  - rd_round>10 or keys_valid=0 (including during expansion): rd_key=0, rd_err=1.
  - Back-to-back reads are allowed every cycle.
  - A read in the same cycle as an accepted start sees keys_valid=1 (old keys) and returns the old key.
- ctr is 4 bits and never exceeds 10; no wrap-around.
- Stage output is ignored in IDLE.

Decomposition:
- Shared package aes_pkg:
  - NR, KEY_W, CTR_W constants.
  - round_idx_t (logic [3:0]).
  - ks_state_t enum {IDLE, LOAD, GEN, STORE}.
  - Round-key store type: array [0:NR] of logic [KEY_W-1:0].
- Sub-module: one instance of the existing key_schedule stage (ports out, in, ctr, clk), which also pulls in g_circuit.
- FSM, counter, store and read port are implemented in this module.

Test Plan:
1. FIPS-197 A.1 vector:
   - Stimulus: reset, then start with key_in=2b7e151628aed2a6abf7158809cf4f3c.
   - Required: busy for 12 cycles, done pulse with keys_valid rising at T12.
   - Read round 0 -> 2b7e151628aed2a6abf7158809cf4f3c; round 1 -> a0fafe1788542cb123a339392a6c7605; round 10 -> d014f9a8c9ee2589e13f0cc8b6630ca6.
2. Reverse sweep: after test 1, rd_en every cycle with rd_round 10 down to 0 -> 11 consecutive rd_valid pulses with the FIPS keys in reverse order, rd_err=0 throughout.
3. Illegal reads:
   - rd_round=11 and 15 -> rd_key=0, rd_err=1.
   - Read during expansion -> rd_err=1.
   - Read after reset before any start -> rd_err=1.
4. Start while busy:
   - Second start with all-zero key at T5 -> ignored; round 10 still d014f9a8c9ee2589e13f0cc8b6630ca6.
   - Then restart with all-zero key -> round 10 = b4ef5bcb3e92e21123e951cf6f8f188e, round 1 = 62636363626363636263636362636363.
5. Reset mid-operation:
   - Assert rst at T6 (asynchronous to clk edge) -> ready=1, busy=0, keys_valid=0 immediately.
   - A later full run produces the correct keys.
6. Restart over valid keys: start accepted while keys_valid=1 -> keys_valid=0 from T1 until T12, reads in that window return rd_err=1, and a read in the accepting cycle returns the old key.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES-128 key-expansion types, constants and byte-level helpers.
// Used by the key expansion controller and the key schedule stage.
package aes_pkg;

    localparam int NR    = 10;
    localparam int KEY_W = 128;
    localparam int CTR_W = 4;

    typedef logic [3:0] round_idx_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        GEN   = 2'd2,
        STORE = 2'd3
    } ks_state_t;

    typedef logic [KEY_W-1:0] rk_store_t [0:NR];

    // Forward S-box, entry 0x00 in the most significant byte.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777b_f26b6fc5_3001672b_fed7ab76,
        128'hca82c97d_fa5947f0_add4a2af_9ca472c0,
        128'hb7fd9326_363ff7cc_34a5e5f1_71d83115,
        128'h04c723c3_1896059a_071280e2_eb27b275,
        128'h09832c1a_1b6e5aa0_523bd6b3_29e32f84,
        128'h53d100ed_20fcb15b_6acbbe39_4a4c58cf,
        128'hd0efaafb_434d3385_45f9027f_503c9fa8,
        128'h51a3408f_929d38f5_bcb6da21_10fff3d2,
        128'hcd0c13ec_5f974417_c4a77e3d_645d1973,
        128'h60814fdc_222a9088_46eeb814_de5e0bdb,
        128'he0323a0a_4906245c_c2d3ac62_9195e479,
        128'he7c8376d_8dd54ea9_6c56f4ea_657aae08,
        128'hba78252e_1ca6b4c6_e8dd741f_4bbd8b8a,
        128'h703eb566_4803f60e_613557b9_86c11d9e,
        128'he1f89811_69d98e94_9b1e87e9_ce5528df,
        128'h8ca1890d_bfe64268_41992d0f_b054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [10:0] base;
        base = 11'd2047 - {b, 3'b000};
        return SBOX_TABLE[base -: 8];
    endfunction

    function automatic logic [7:0] rcon(input round_idx_t k);
        logic [7:0] r;
        case (k)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h1b;
            4'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/key_schedule.sv
// Single-round AES-128 key schedule stage: ctr=0 loads the cipher key,
// ctr=k advances the registered round key by one round using Rcon[k].
module g_circuit
    import aes_pkg::*;
(
    input  logic [31:0] w,
    input  round_idx_t  ctr,
    output logic [31:0] g
);
    logic [31:0] rot;

    always_comb begin
        rot = {w[23:0], w[31:24]};
        g   = {sbox(rot[31:24]) ^ rcon(ctr), sbox(rot[23:16]),
               sbox(rot[15:8]), sbox(rot[7:0])};
    end
endmodule

module key_schedule
    import aes_pkg::*;
(
    output logic [127:0] out,
    input  logic [127:0] in,
    input  round_idx_t   ctr,
    input  logic         clk
);
    logic [31:0]  g_word;
    logic [31:0]  n0, n1, n2, n3;

    g_circuit u_g (
        .w   (out[31:0]),
        .ctr (ctr),
        .g   (g_word)
    );

    always_comb begin
        n0 = out[127:96] ^ g_word;
        n1 = out[95:64]  ^ n0;
        n2 = out[63:32]  ^ n1;
        n3 = out[31:0]   ^ n2;
    end

    always_ff @(posedge clk) begin
        if (ctr == 4'd0) out <= in;
        else             out <= {n0, n1, n2, n3};
    end
endmodule

// File: rtl/key_expansion_ctrl.sv
// Sequences the AES-128 key schedule stage through rounds 0..10, stores all
// round keys and serves them through a registered indexed read port.
module key_expansion_ctrl #(
    parameter int NR    = 10,
    parameter int KEY_W = 128,
    parameter int CTR_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [KEY_W-1:0] key_in,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic             keys_valid,
    input  logic             rd_en,
    input  logic [3:0]       rd_round,
    output logic [KEY_W-1:0] rd_key,
    output logic             rd_valid,
    output logic             rd_err
);
    import aes_pkg::*;

    if (NR != 10 || KEY_W != 128 || CTR_W != 4) begin : g_bad_cfg
        $error("key_expansion_ctrl supports AES-128 only (NR=10, KEY_W=128, CTR_W=4)");
    end

    localparam logic [CTR_W-1:0] LAST = CTR_W'(NR);

    ks_state_t        state;
    logic [CTR_W-1:0] ctr;
    logic [KEY_W-1:0] key_reg;
    logic [KEY_W-1:0] stage_out;
    rk_store_t        store;
    logic             accept;
    logic             rd_legal;

    assign accept = (state == IDLE) && start;
    assign ready  = (state == IDLE);
    assign busy   = (state != IDLE);

    key_schedule u_stage (
        .out (stage_out),
        .in  (key_reg),
        .ctr (ctr),
        .clk (clk)
    );

    always_ff @(posedge clk) begin
        if (accept) key_reg <= key_in;
    end

    // ctr is cleared only on acceptance so the stage reloads during LOAD alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            ctr        <= '0;
            keys_valid <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= LOAD;
                        ctr        <= '0;
                        keys_valid <= 1'b0;
                    end
                end
                LOAD: begin
                    state <= GEN;
                    ctr   <= CTR_W'(1);
                end
                GEN: begin
                    if (ctr == LAST) state <= STORE;
                    else             ctr   <= ctr + CTR_W'(1);
                end
                STORE: begin
                    keys_valid <= 1'b1;
                    done       <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // In GEN the stage output lags ctr by one round.
    always_ff @(posedge clk) begin
        if (state == GEN)        store[ctr - CTR_W'(1)] <= stage_out;
        else if (state == STORE) store[NR]              <= stage_out;
    end

    assign rd_legal = keys_valid && (rd_round <= 4'(NR));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_key   <= '0;
            rd_valid <= 1'b0;
            rd_err   <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            rd_err   <= rd_en && !rd_legal;
            if (rd_en) begin
                if (rd_legal) rd_key <= store[rd_round];
                else          rd_key <= '0;
            end
        end
    end

endmodule
